// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
package sha256_pkg;

  localparam int unsigned BLOCK_W       = 512;
  localparam int unsigned LEN_W         = 64;
  localparam int unsigned BLOCK_BYTES   = 64;
  localparam int unsigned PAD_LEN_LIMIT = 55;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SEND  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PAD2  = 2'd3
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_fill.sv
// Combinational block builder: keeps the first i_nbytes bytes of i_buf, optionally
// places the 0x80 marker right after them and the big-endian bit length in [63:0].
module sha256_pad_fill
  import sha256_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_buf,
  input  logic [6:0]         i_nbytes,
  input  logic               i_place_mark,
  input  logic               i_place_len,
  input  logic [LEN_W-1:0]   i_len,
  output logic [BLOCK_W-1:0] o_block
);

  logic [31:0] w_nbytes;
  assign w_nbytes = {25'd0, i_nbytes};

  always_comb begin
    o_block = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (i < w_nbytes)
        o_block[BLOCK_W-1-8*i -: 8] = i_buf[BLOCK_W-1-8*i -: 8];
      else if ((i == w_nbytes) && i_place_mark)
        o_block[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
    end
    if (i_place_len)
      o_block[LEN_W-1:0] = i_len;
  end

endmodule

// File: rtl/sha256_padder.sv
// Byte-stream front-end for the sha256 core: assembles 512-bit blocks with FIPS 180-4
// padding. Optional block counter port enabled by macro SHA256_PAD_STATS_EN.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               empty_msg,
  output logic               blk_start,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_last,
  input  logic               core_done,
  output logic               msg_done
`ifdef SHA256_PAD_STATS_EN
  ,
  output logic [31:0]        blk_count
`endif
);

  pad_state_t         r_state;
  logic [BLOCK_W-1:0] r_buf;
  logic [6:0]         r_n;
  logic [LEN_W-1:0]   r_len;
  logic               r_pad_pend;
  logic               r_mark_pend;
  logic [BLOCK_W-1:0] r_blk_data;
  logic               r_blk_last;
  logic               r_msg_done;

  logic [BLOCK_W-1:0] w_buf_next;
  logic [6:0]         w_n_next;
  logic [LEN_W-1:0]   w_len_next;
  logic [8:0]         w_bit_hi;
  logic [BLOCK_W-1:0] w_fill_buf;
  logic [6:0]         w_fill_n;
  logic               w_fill_mark;
  logic               w_fill_len_en;
  logic [LEN_W-1:0]   w_fill_len;
  logic [BLOCK_W-1:0] w_block;
  logic               w_fits_len;

  assign w_bit_hi   = 9'(BLOCK_W - 1) - {r_n[5:0], 3'b000};
  assign w_n_next   = r_n + 7'd1;
  assign w_len_next = r_len + 64'd8;
  assign w_fits_len = (w_n_next <= 7'(PAD_LEN_LIMIT));

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[w_bit_hi -: 8] = in_data;
  end

  // One fill instance is shared: PAD2 feeds an empty buffer, ACCUM feeds the
  // buffer including the byte being accepted, and an idle ACCUM serves empty_msg.
  always_comb begin
    w_fill_buf    = '0;
    w_fill_n      = '0;
    w_fill_mark   = 1'b1;
    w_fill_len_en = 1'b1;
    w_fill_len    = r_len;
    if (r_state == ST_PAD2) begin
      w_fill_mark = r_mark_pend;
    end else if (in_valid) begin
      w_fill_buf    = w_buf_next;
      w_fill_n      = w_n_next;
      w_fill_mark   = in_last && (w_n_next != 7'(BLOCK_BYTES));
      w_fill_len_en = in_last && w_fits_len;
      w_fill_len    = w_len_next;
    end
  end

  sha256_pad_fill u_fill (
    .i_buf        (w_fill_buf),
    .i_nbytes     (w_fill_n),
    .i_place_mark (w_fill_mark),
    .i_place_len  (w_fill_len_en),
    .i_len        (w_fill_len),
    .o_block      (w_block)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_buf       <= '0;
      r_n         <= '0;
      r_len       <= '0;
      r_pad_pend  <= 1'b0;
      r_mark_pend <= 1'b0;
      r_blk_data  <= '0;
      r_blk_last  <= 1'b0;
      r_msg_done  <= 1'b0;
    end else begin
      r_msg_done <= 1'b0;
      case (r_state)
        ST_ACCUM: begin
          if (in_valid) begin
            r_buf <= w_buf_next;
            r_n   <= w_n_next;
            r_len <= w_len_next;
            if (in_last || (w_n_next == 7'(BLOCK_BYTES))) begin
              r_blk_data  <= w_block;
              r_blk_last  <= in_last && w_fits_len;
              r_pad_pend  <= in_last && !w_fits_len;
              r_mark_pend <= in_last && (w_n_next == 7'(BLOCK_BYTES));
              r_state     <= ST_SEND;
            end
          end else if (empty_msg && (r_n == '0)) begin
            r_blk_data <= w_block;
            r_blk_last <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            if (r_blk_last) begin
              r_msg_done <= 1'b1;
              r_len      <= '0;
              r_n        <= '0;
              r_state    <= ST_ACCUM;
            end else if (r_pad_pend) begin
              r_state <= ST_PAD2;
            end else begin
              r_n     <= '0;
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_PAD2: begin
          r_blk_data  <= w_block;
          r_blk_last  <= 1'b1;
          r_pad_pend  <= 1'b0;
          r_mark_pend <= 1'b0;
          r_n         <= '0;
          r_state     <= ST_SEND;
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign blk_start = (r_state == ST_SEND);
  assign blk_data  = r_blk_data;
  assign blk_last  = r_blk_last;
  assign msg_done  = r_msg_done;

`ifdef SHA256_PAD_STATS_EN
  logic [31:0] r_blk_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_blk_count <= '0;
    else if (r_state == ST_SEND)
      r_blk_count <= r_blk_count + 32'd1;
  end

  assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: expected blocks are queued by the stimulus and
// popped by a monitor on every blk_start; a core model answers with core_done.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic         empty_msg;
  logic         blk_start;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         core_done;
  logic         msg_done;
`ifdef SHA256_PAD_STATS_EN
  logic [31:0]  blk_count;
  int           exp_cnt = 0;
`endif

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .empty_msg (empty_msg),
    .blk_start (blk_start),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .core_done (core_done),
    .msg_done  (msg_done)
`ifdef SHA256_PAD_STATS_EN
    ,
    .blk_count (blk_count)
`endif
  );

  int errors = 0;
  int checks = 0;
  int msgs = 0;
  int core_delay = 3;
  logic [511:0] q_data[$];
  logic         q_last[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  task automatic push_exp(input logic [511:0] d, input logic l);
    q_data.push_back(d);
    q_last.push_back(l);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic em);
    int tries = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; empty_msg = 1'b0;
      tries++;
    end while (!in_ready && tries < 300);
    if (!in_ready) fail_now("send_ready");
    in_valid = 1'b1; in_data = d; in_last = l; empty_msg = em;
  endtask

  task automatic end_msg();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; empty_msg = 1'b0;
  endtask

  task automatic send_run(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) send_byte(v, (i == n - 1), 1'b0);
    end_msg();
  endtask

  task automatic wait_msgs(input int target);
    int t = 0;
    while (msgs < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (msgs < target) fail_now("msg_wait");
  endtask

  // Monitor: sampled 1 time unit after the active edge
  initial begin
    logic [511:0] ed;
    logic         el;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
`ifdef SHA256_PAD_STATS_EN
        exp_cnt = 0;
`endif
      end else begin
        if (core_done || msg_done) check("msg_done", msg_done, core_done && blk_last);
        if (msg_done) msgs++;
        if (blk_start) begin
          if (q_data.size() == 0) begin
            checks++; errors++;
            $display("FAIL blk_unexpected: got block %h expected none", blk_data);
          end else begin
            ed = q_data.pop_front();
            el = q_last.pop_front();
            check("blk_data", blk_data, ed);
            check("blk_last", blk_last, el);
          end
`ifdef SHA256_PAD_STATS_EN
          check("blk_count", blk_count, exp_cnt);
          exp_cnt++;
`endif
        end
      end
    end
  end

  // Core model: holds off core_done for core_delay cycles, verifying the block stays put
  initial begin
    logic [511:0] hd;
    logic         hl;
    logic         ok;
    logic         aborted;
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (blk_start && !rst) begin
        hd = blk_data; hl = blk_last; ok = 1'b1; aborted = 1'b0;
        for (int i = 0; i < core_delay; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (aborted) break;
          if (blk_data !== hd || blk_last !== hl || in_ready !== 1'b0 || blk_start !== 1'b0)
            ok = 1'b0;
        end
        if (!aborted) begin
          check("wait_hold", ok, 1'b1);
          core_done = 1'b1;
          @(negedge clk);
          core_done = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [511:0] e;
    logic         rdy_ok;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; empty_msg = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_blk_start", blk_start, 1'b0);
    check("rst_blk_data", blk_data, '0);
    check("rst_blk_last", blk_last, 1'b0);
    check("rst_msg_done", msg_done, 1'b0);

    // "abc"
    e = '0; e[511:480] = 32'h61626380; e[63:0] = 64'h18;
    push_exp(e, 1'b1);
    send_byte(8'h61, 1'b0, 1'b0); send_byte(8'h62, 1'b0, 1'b0); send_byte(8'h63, 1'b1, 1'b0);
    end_msg();
    wait_msgs(1);

    // zero-length message
    e = '0; e[511:504] = 8'h80;
    push_exp(e, 1'b1);
    @(negedge clk); empty_msg = 1'b1;
    @(negedge clk); empty_msg = 1'b0;
    wait_msgs(2);

    // 55 bytes: length still fits
    e = '0; e[71:64] = 8'h80; e[63:0] = 64'h1b8;
    push_exp(e, 1'b1);
    send_run(55, 8'h00);
    wait_msgs(3);

    // 56 bytes: marker in first block, length in second
    push_exp({{56{8'h5a}}, 8'h80, 56'h0}, 1'b0);
    e = '0; e[63:0] = 64'h1c0;
    push_exp(e, 1'b1);
    send_run(56, 8'h5a);
    wait_msgs(4);

    // 64 bytes: marker owed to second block
    push_exp('1, 1'b0);
    e = '0; e[511:504] = 8'h80; e[63:0] = 64'h200;
    push_exp(e, 1'b1);
    send_run(64, 8'hff);
    wait_msgs(5);

    // empty_msg coinciding with a byte, and with bytes buffered, is dropped
    e = '0; e[511:480] = 32'h01020380; e[63:0] = 64'h18;
    push_exp(e, 1'b1);
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0; empty_msg = 1'b1;
    @(negedge clk); empty_msg = 1'b0;
    send_byte(8'h03, 1'b1, 1'b0);
    end_msg();
    wait_msgs(6);

    // long core latency: in_ready low throughout
    core_delay = 80;
    e = '0; e[511:480] = 32'h61626380; e[63:0] = 64'h18;
    push_exp(e, 1'b1);
    send_byte(8'h61, 1'b0, 1'b0); send_byte(8'h62, 1'b0, 1'b0); send_byte(8'h63, 1'b1, 1'b0);
    end_msg();
    rdy_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) rdy_ok = 1'b0;
    end
    check("wait_in_ready", rdy_ok, 1'b1);
    wait_msgs(7);

    // reset mid-WAIT drops the block; a following "abc" must restart length at zero
    push_exp(e, 1'b1);
    send_byte(8'h61, 1'b0, 1'b0); send_byte(8'h62, 1'b0, 1'b0); send_byte(8'h63, 1'b1, 1'b0);
    end_msg();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_blk_start", blk_start, 1'b0);
    check("mid_rst_blk_data", blk_data, '0);
    check("mid_rst_blk_last", blk_last, 1'b0);
    check("mid_rst_msg_done", msg_done, 1'b0);
    rst = 1'b0;
    core_delay = 3;
    repeat (2) @(negedge clk);
    push_exp(e, 1'b1);
    send_byte(8'h61, 1'b0, 1'b0); send_byte(8'h62, 1'b0, 1'b0); send_byte(8'h63, 1'b1, 1'b0);
    end_msg();
    wait_msgs(8);

    repeat (5) @(negedge clk);
    check("queue_empty", q_data.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
